trap_ctrl_v2: RTL and testbench
===============================

Name: trap_ctrl_v2

Overview:
Parametrised successor to the single-cycle trap vector unit. It arbitrates synchronous exceptions against NUM_IRQ maskable supervisor interrupts and sequences the pipeline flush. It writes sepc/scause/stval through one-cycle CSR write strobes, supports direct and vectored stvec modes, and handles sret with an internal SIE/SPIE stack. It sits between the execute/commit stage and the CSR file, and drives the fetch redirect.

Parameters:
XLEN, 32, datapath/CSR width
NUM_IRQ, 8, number of interrupt lines (1..16)
CAUSE_W, 5, width of exception cause code
IRQ_CAUSE_BASE, 16, scause code of irq line 0 (line i -> BASE+i)
VECTORED_EN, 1, 0 forces direct mode regardless of stvec[1:0]

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
exc_req  in  1  synchronous exception at commit, level, held until trap_take
exc_cause  in  CAUSE_W  exception code
exc_tval  in  XLEN  faulting address/instruction
cur_pc  in  XLEN  PC of the committing/faulting instruction
irq_pending  in  NUM_IRQ  raw interrupt lines
irq_enable  in  NUM_IRQ  per-line enables (sie CSR)
stvec_q  in  XLEN  base[XLEN-1:2], mode[1:0] (0 direct, 1 vectored)
sepc_q  in  XLEN  current sepc, used as the sret target
sret_req  in  1  sret at commit, level, held until ret_take
pipe_drained  in  1  pipeline flushed / no stores in flight
flush_req  out  1  request pipeline flush
trap_take  out  1  one-cycle pulse; trap committed
ret_take  out  1  one-cycle pulse; sret committed
redirect_valid  out  1  one-cycle fetch redirect
redirect_pc  out  XLEN  redirect target
sepc_we / sepc_wdata  out  1 / XLEN  sepc write
scause_we / scause_wdata  out  1 / XLEN  scause write; bit XLEN-1 = interrupt
stval_we / stval_wdata  out  1 / XLEN  stval write (0 for interrupts)
sie_q / spie_q  out  1 / 1  global interrupt enable and its saved copy
busy  out  1  FSM not in IDLE
double_fault  out  1  sticky; exception raised while already in TRAP_FLUSH

Behaviour:
- Reset (async, rst=1): FSM=IDLE.
  - All outputs 0 except spie_q=1; sie_q=0.
  - Latched cause, tval and pc are cleared to 0.
- irq_sel: the lowest-index bit of (irq_pending & irq_enable). An interrupt is eligible only when sie_q=1 and the FSM is in IDLE.
- Priority in IDLE: exc_req > sret_req > eligible interrupt.
- FSM states: IDLE, TRAP_FLUSH, TRAP_COMMIT, RET_FLUSH, RET_COMMIT.
- IDLE -> TRAP_FLUSH on exc_req or eligible interrupt.
  - Latch is_irq, cause (exc_cause zero-extended, or IRQ_CAUSE_BASE+idx), tval (exc_tval or 0) and pc=cur_pc.
  - Assert flush_req from the next cycle.
- IDLE -> RET_FLUSH on sret_req when no exception is present. Assert flush_req.
- TRAP_FLUSH: hold until pipe_drained=1, then go to TRAP_COMMIT.
  - If pipe_drained is already high on entry, minimum latency from request to trap_take is 2 cycles.
  - Changes on irq_pending are ignored here; the cause is already latched.
- TRAP_COMMIT (exactly 1 cycle):
  - Pulse trap_take, redirect_valid, sepc_we, scause_we and stval_we.
  - spie_q <= sie_q; sie_q <= 0.
  - Deassert flush_req. Return to IDLE.
- redirect_pc rule:
  - Direct mode, or any exception: {stvec_q[XLEN-1:2],2'b00}.
  - Vectored mode (VECTORED_EN=1, stvec_q[1:0]=1) and an interrupt: base + 4*cause, truncated to XLEN.
  - stvec_q[1:0] in {2,3} is treated as direct.
- RET_FLUSH: wait for pipe_drained, then go to RET_COMMIT.
- RET_COMMIT (1 cycle):
  - Pulse ret_take and redirect_valid, with redirect_pc=sepc_q.
  - sie_q <= spie_q; spie_q <= 1. Return to IDLE.
- exc_req=1 in TRAP_FLUSH with the latched trap being an exception and a different cause: set double_fault.
  - double_fault is sticky until reset. The trap proceeds with the original latched values.
- exc_req arriving during RET_FLUSH is serviced after RET_COMMIT returns to IDLE. It is not lost, because it is held at the level.
- Interrupts that deassert before the FSM leaves IDLE are never taken. No edge latching.
- Outputs are registered. Every strobe is high for exactly one cycle per event. No two events commit in the same cycle.

Decomposition:
- Shared package (harvos_pkg): trap_state_e enum, TVEC_MODE_DIRECT/VECTORED constants, IRQ_CAUSE_BASE default, and the scause interrupt-bit position.
- One sub-module: irq_prio_enc, a parametrised lowest-index priority encoder with NUM_IRQ inputs and a valid + index output.

Test Plan:
- Illegal-instruction exc_req, cause=2, tval=0xDEADBEEF, cur_pc=0x100, stvec=0x8000_0001, pipe_drained=1:
  - trap_take on cycle 2.
  - redirect_pc=0x8000_0000, scause=0x2, stval=0xDEADBEEF, sepc=0x100.
  - sie_q=0.
- sie_q=1, irq_pending=0b0110, irq_enable=0b0100, vectored stvec=0x8000_0001:
  - scause=0x8000_0012, redirect_pc=0x8000_0048, stval=0.
- exc_req and eligible irq in the same cycle: exception taken, scause bit31=0; the interrupt is taken after the first trap, once sie is restored via sret.
- Trap pending with pipe_drained held low 5 cycles: flush_req stays high, no strobes, trap_take on the cycle after pipe_drained rises.
- sret_req with sepc_q=0x200, spie_q=1: ret_take and redirect to 0x200, sie_q=1, spie_q=1.
- rst asserted during TRAP_FLUSH: immediate return to IDLE, all strobes 0, no trap_take after deassert.
- Second exception with a different cause during TRAP_FLUSH: double_fault=1 and stays set.

Source files
------------

// File: rtl/harvos_pkg.sv
// Shared types and constants for the trap controller slice.
package harvos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_TRAP_FLUSH  = 3'd1,
    ST_TRAP_COMMIT = 3'd2,
    ST_RET_FLUSH   = 3'd3,
    ST_RET_COMMIT  = 3'd4
  } trap_state_e;

  localparam logic [1:0] TVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] TVEC_MODE_VECTORED = 2'd1;

  localparam int IRQ_CAUSE_BASE_DEF = 16;

  // scause carries the interrupt flag in its MSB
  function automatic int scause_irq_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/trap_ctrl_v2_irq_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt lines.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // scanning downward lets the lowest set bit overwrite higher ones
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/trap_ctrl_v2.sv
// Trap/sret sequencer: arbitrates exceptions vs. interrupts, drains the pipe,
// then commits CSR writes and the fetch redirect in a single cycle.
//
//   state        | meaning
//   IDLE         | waiting for exception, sret or eligible interrupt
//   TRAP_FLUSH   | trap latched, flush_req high, waiting for pipe_drained
//   TRAP_COMMIT  | one cycle: CSR strobes, redirect to stvec, SIE stacked
//   RET_FLUSH    | sret accepted, flush_req high, waiting for pipe_drained
//   RET_COMMIT   | one cycle: redirect to sepc, SIE restored
module trap_ctrl_v2
  import harvos_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_IRQ        = 8,
  parameter int CAUSE_W        = 5,
  parameter int IRQ_CAUSE_BASE = IRQ_CAUSE_BASE_DEF,
  parameter int VECTORED_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_req,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [XLEN-1:0]    cur_pc,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [XLEN-1:0]    stvec_q,
  input  logic [XLEN-1:0]    sepc_q,
  input  logic               sret_req,
  input  logic               pipe_drained,
  output logic               flush_req,
  output logic               trap_take,
  output logic               ret_take,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               sepc_we,
  output logic [XLEN-1:0]    sepc_wdata,
  output logic               scause_we,
  output logic [XLEN-1:0]    scause_wdata,
  output logic               stval_we,
  output logic [XLEN-1:0]    stval_wdata,
  output logic               sie_q,
  output logic               spie_q,
  output logic               busy,
  output logic               double_fault
);

  localparam int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int IRQ_BIT = scause_irq_bit(XLEN);

  trap_state_e        state_q, state_d;
  logic               lat_irq_q, lat_irq_d;
  logic [CAUSE_W-1:0] lat_cause_q, lat_cause_d;
  logic [XLEN-1:0]    lat_tval_q, lat_tval_d;
  logic [XLEN-1:0]    lat_pc_q;
  logic               lat_en;

  logic               irq_valid;
  logic [IDX_W-1:0]   irq_idx;
  logic               irq_eligible;

  logic               trap_commit, ret_commit, dfault_set, vec_mode;
  logic [XLEN-1:0]    tvec_base, trap_pc, scause_val;

  irq_prio_enc #(
    .NUM_IRQ(NUM_IRQ),
    .IDX_W  (IDX_W)
  ) u_irq_prio_enc (
    .req  (irq_pending & irq_enable),
    .valid(irq_valid),
    .idx  (irq_idx)
  );

  assign irq_eligible = sie_q & irq_valid;

  always_comb begin
    state_d     = state_q;
    lat_en      = 1'b0;
    lat_irq_d   = 1'b0;
    lat_cause_d = lat_cause_q;
    lat_tval_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (exc_req) begin
          state_d     = ST_TRAP_FLUSH;
          lat_en      = 1'b1;
          lat_cause_d = exc_cause;
          lat_tval_d  = exc_tval;
        end else if (sret_req) begin
          state_d = ST_RET_FLUSH;
        end else if (irq_eligible) begin
          state_d     = ST_TRAP_FLUSH;
          lat_en      = 1'b1;
          lat_irq_d   = 1'b1;
          lat_cause_d = CAUSE_W'(IRQ_CAUSE_BASE) + CAUSE_W'(irq_idx);
        end
      end
      ST_TRAP_FLUSH:  if (pipe_drained) state_d = ST_TRAP_COMMIT;
      ST_TRAP_COMMIT: state_d = ST_IDLE;
      ST_RET_FLUSH:   if (pipe_drained) state_d = ST_RET_COMMIT;
      ST_RET_COMMIT:  state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trap_commit = (state_d == ST_TRAP_COMMIT);
    ret_commit  = (state_d == ST_RET_COMMIT);
    dfault_set  = (state_q == ST_TRAP_FLUSH) && exc_req && !lat_irq_q &&
                  (exc_cause != lat_cause_q);
    tvec_base   = {stvec_q[XLEN-1:2], 2'b00};
    vec_mode    = (VECTORED_EN != 0) && (stvec_q[1:0] == TVEC_MODE_VECTORED);
    // only interrupts are vectored; exceptions always land on the base
    trap_pc     = (vec_mode && lat_irq_q) ? tvec_base + (XLEN'(lat_cause_q) << 2)
                                          : tvec_base;
    scause_val          = XLEN'(lat_cause_q);
    scause_val[IRQ_BIT] = lat_irq_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_irq_q      <= 1'b0;
      lat_cause_q    <= '0;
      lat_tval_q     <= '0;
      lat_pc_q       <= '0;
      flush_req      <= 1'b0;
      busy           <= 1'b0;
      trap_take      <= 1'b0;
      ret_take       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      sepc_we        <= 1'b0;
      sepc_wdata     <= '0;
      scause_we      <= 1'b0;
      scause_wdata   <= '0;
      stval_we       <= 1'b0;
      stval_wdata    <= '0;
      sie_q          <= 1'b0;
      spie_q         <= 1'b1;
      double_fault   <= 1'b0;
    end else begin
      if (lat_en) begin
        lat_irq_q   <= lat_irq_d;
        lat_cause_q <= lat_cause_d;
        lat_tval_q  <= lat_tval_d;
        lat_pc_q    <= cur_pc;
      end
      flush_req      <= (state_d == ST_TRAP_FLUSH) || (state_d == ST_RET_FLUSH);
      busy           <= (state_d != ST_IDLE);
      trap_take      <= trap_commit;
      ret_take       <= ret_commit;
      redirect_valid <= trap_commit | ret_commit;
      redirect_pc    <= trap_commit ? trap_pc : (ret_commit ? sepc_q : '0);
      sepc_we        <= trap_commit;
      sepc_wdata     <= trap_commit ? lat_pc_q : '0;
      scause_we      <= trap_commit;
      scause_wdata   <= trap_commit ? scause_val : '0;
      stval_we       <= trap_commit;
      stval_wdata    <= trap_commit ? lat_tval_q : '0;
      if (trap_commit) begin
        spie_q <= sie_q;
        sie_q  <= 1'b0;
      end else if (ret_commit) begin
        sie_q  <= spie_q;
        spie_q <= 1'b1;
      end
      if (dfault_set) double_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trap_ctrl_v2.sv
// Directed self-checking bench for trap_ctrl_v2 (default parameters).
module tb_trap_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic [31:0] exc_tval, cur_pc, stvec_q, sepc_q;
  logic [7:0]  irq_pending, irq_enable;
  logic        sret_req, pipe_drained;
  logic        flush_req, trap_take, ret_take, redirect_valid;
  logic [31:0] redirect_pc;
  logic        sepc_we, scause_we, stval_we;
  logic [31:0] sepc_wdata, scause_wdata, stval_wdata;
  logic        sie_q, spie_q, busy, double_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl_v2 dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .exc_cause(exc_cause),
    .exc_tval(exc_tval), .cur_pc(cur_pc), .irq_pending(irq_pending),
    .irq_enable(irq_enable), .stvec_q(stvec_q), .sepc_q(sepc_q),
    .sret_req(sret_req), .pipe_drained(pipe_drained), .flush_req(flush_req),
    .trap_take(trap_take), .ret_take(ret_take), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .sepc_we(sepc_we), .sepc_wdata(sepc_wdata),
    .scause_we(scause_we), .scause_wdata(scause_wdata), .stval_we(stval_we),
    .stval_wdata(stval_wdata), .sie_q(sie_q), .spie_q(spie_q), .busy(busy),
    .double_fault(double_fault)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_trap(input int budget, output int n);
    n = 0;
    while (trap_take !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ret(input int budget, output int n);
    n = 0;
    while (ret_take !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic chk_trap(input string tag, input logic [31:0] e_sepc,
                          input logic [31:0] e_scause, input logic [31:0] e_stval,
                          input logic [31:0] e_rpc);
    chkw({tag, "_strobes"},
         32'({trap_take, redirect_valid, sepc_we, scause_we, stval_we, ret_take}),
         32'b111110);
    chkw({tag, "_sepc"}, sepc_wdata, e_sepc);
    chkw({tag, "_scause"}, scause_wdata, e_scause);
    chkw({tag, "_stval"}, stval_wdata, e_stval);
    chkw({tag, "_rpc"}, redirect_pc, e_rpc);
    chk1({tag, "_flush"}, flush_req, 1'b0);
  endtask

  task automatic do_sret(input string tag, input logic exp_sie);
    int n;
    sret_req = 1'b1;
    wait_ret(10, n);
    chkw({tag, "_lat"}, 32'(n), 32'd2);
    chkw({tag, "_strobes"},
         32'({ret_take, redirect_valid, trap_take, sepc_we, scause_we, stval_we}),
         32'b110000);
    chkw({tag, "_rpc"}, redirect_pc, 32'h0000_0200);
    chk1({tag, "_sie"}, sie_q, exp_sie);
    chk1({tag, "_spie"}, spie_q, 1'b1);
    sret_req = 1'b0;
    step();
    chk1({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    exc_req = 1'b0; exc_cause = '0; exc_tval = '0; cur_pc = '0;
    irq_pending = '0; irq_enable = '0; stvec_q = 32'h8000_0001;
    sepc_q = 32'h0000_0200; sret_req = 1'b0; pipe_drained = 1'b1;
    repeat (3) step();
    chkw("rst_outs",
         32'({flush_req, trap_take, ret_take, redirect_valid, sepc_we, scause_we,
              stval_we, busy, double_fault}), 32'd0);
    chk1("rst_sie", sie_q, 1'b0);
    chk1("rst_spie", spie_q, 1'b1);
    chkw("rst_rpc", redirect_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // illegal instruction exception, pipe already drained
    exc_req = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD_BEEF; cur_pc = 32'h100;
    step();
    n = 1;
    chk1("exc1_flush", flush_req, 1'b1);
    chk1("exc1_busy", busy, 1'b1);
    chk1("exc1_early", trap_take, 1'b0);
    step();
    n = 2;
    chk1("exc1_take", trap_take, 1'b1);
    chk_trap("exc1", 32'h100, 32'h2, 32'hDEAD_BEEF, 32'h8000_0000);
    chk1("exc1_sie", sie_q, 1'b0);
    chk1("exc1_spie", spie_q, 1'b0);
    exc_req = 1'b0;
    step();
    chkw("exc1_after", 32'({trap_take, redirect_valid, sepc_we, busy}), 32'd0);

    // two srets: SPIE restored to 1, then SIE raised to 1
    do_sret("sret1", 1'b0);
    do_sret("sret2", 1'b1);

    // vectored interrupt: line 2 is the lowest enabled pending line
    cur_pc = 32'h300; irq_pending = 8'b0110; irq_enable = 8'b0100;
    wait_trap(10, n);
    chkw("irq_lat", 32'(n), 32'd2);
    chk_trap("irq", 32'h300, 32'h8000_0012, 32'h0, 32'h8000_0048);
    chk1("irq_sie", sie_q, 1'b0);
    chk1("irq_spie", spie_q, 1'b1);
    irq_pending = '0;
    step();

    do_sret("sret3", 1'b1);

    // exception and interrupt together: exception wins
    cur_pc = 32'h400; exc_req = 1'b1; exc_cause = 5'd5; exc_tval = 32'h1234;
    irq_pending = 8'b0001; irq_enable = 8'b0001;
    wait_trap(10, n);
    chkw("both_lat", 32'(n), 32'd2);
    chk_trap("both", 32'h400, 32'h5, 32'h1234, 32'h8000_0000);
    exc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("both_irq_masked", busy, 1'b0);
    end
    do_sret("sret4", 1'b1);
    cur_pc = 32'h500;
    wait_trap(10, n);
    chkw("late_irq_lat", 32'(n), 32'd2);
    chk_trap("late_irq", 32'h500, 32'h8000_0010, 32'h0, 32'h8000_0040);
    irq_pending = '0;
    step();

    // pipe not drained for 5 cycles
    pipe_drained = 1'b0; exc_req = 1'b1; exc_cause = 5'd3; exc_tval = 32'h77;
    cur_pc = 32'h600;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chkw("stall_hold", 32'({flush_req, trap_take, sepc_we, scause_we, stval_we}),
           32'b10000);
    end
    chk1("stall_no_df", double_fault, 1'b0);
    pipe_drained = 1'b1;
    step();
    chk1("stall_take", trap_take, 1'b1);
    chk_trap("stall", 32'h600, 32'h3, 32'h77, 32'h8000_0000);
    exc_req = 1'b0;
    step();

    // asynchronous reset in TRAP_FLUSH
    pipe_drained = 1'b0; exc_req = 1'b1; exc_cause = 5'd4;
    step();
    chk1("rstf_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chkw("rstf_outs", 32'({flush_req, trap_take, busy, sepc_we, scause_we,
                           stval_we, redirect_valid}), 32'd0);
    chk1("rstf_spie", spie_q, 1'b1);
    exc_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pipe_drained = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chkw("rstf_quiet", 32'({trap_take, busy}), 32'd0);
    end

    // second exception with a different cause while flushing
    pipe_drained = 1'b0; exc_req = 1'b1; exc_cause = 5'd2; exc_tval = 32'hAA;
    cur_pc = 32'h700;
    step();
    step();
    chk1("df_same_cause", double_fault, 1'b0);
    exc_cause = 5'd7; exc_tval = 32'hBB;
    step();
    chk1("df_set", double_fault, 1'b1);
    pipe_drained = 1'b1;
    step();
    chk1("df_take", trap_take, 1'b1);
    chk_trap("df", 32'h700, 32'h2, 32'hAA, 32'h8000_0000);
    exc_req = 1'b0;
    repeat (3) step();
    chk1("df_sticky", double_fault, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
